burst_mem_responder: RTL and testbench
======================================

Name: burst_mem_responder

Overview:
- Physical-memory side of the 64-bit burst interface driven by cacheline_adaptor.
- Accepts line read and line write requests and answers with 4-beat bursts of 64 bits (one 256-bit cache line).
- Has a configurable access latency and a small on-chip line store.
- Serves as the synthesizable memory model below mp4, and as the responder the adaptor is verified against.

Parameters:
- LATENCY, 4, cycles from request acceptance to first mem_resp beat; minimum 1.
- INDEX_BITS, 4, log2 of line-store depth (default 16 lines of 256 bits).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_read  in  1  line read request, held high until the transaction ends.
- mem_write  in  1  line write request, held high until the transaction ends.
- mem_addr  in  32  line address; bits [4:0] ignored; line index = mem_addr[5+:INDEX_BITS]; upper bits ignored (aliasing wraps modulo depth).
- mem_wdata  in  64  write beat data, sampled in each cycle mem_resp=1 during a write.
- mem_rdata  out  64  read beat data, valid in each cycle mem_resp=1 during a read.
- mem_resp  out  1  beat strobe; exactly 4 consecutive high cycles per completed transaction.
- proto_err  out  1  sticky protocol-violation flag; cleared only by reset.

Behaviour:
- Reset (asynchronous assert, synchronous deassert edge not required): state=IDLE, mem_resp=0, mem_rdata=0, proto_err=0, counters=0. The line store is NOT cleared.
- States: IDLE, WAIT, BURST, DONE.
- IDLE:
  - mem_read or mem_write high at a clock edge -> latch op, index; latency counter = LATENCY-1.
  - Next state is WAIT, or BURST directly if LATENCY=1.
  - mem_read and mem_write both high -> proto_err=1, treat as read.
- WAIT: decrement counter each cycle; at 0 -> BURST with beat=0.
- First mem_resp is high in cycle t+LATENCY, where t is the cycle the request was first sampled high.
- BURST:
  - mem_resp=1 for beats 0..3; beat k carries line bits [64k+63:64k].
  - Read: mem_rdata = stored beat k (registered output).
  - Write: mem_wdata is written into beat k of the latched line at the end of that cycle; each beat commits individually.
  - After beat 3 -> DONE.
- DONE: mem_resp=0. Return to IDLE on the first cycle with mem_read=0 and mem_write=0. A new request is never accepted in the same cycle the old one drops, so there is at least one idle cycle between transactions.
- Outside BURST: mem_rdata holds its last value; mem_resp=0.
- mem_addr and op changes after acceptance are ignored; the latched values govern the transaction.
- Request dropped while in WAIT or BURST -> proto_err=1, abort to IDLE immediately, mem_resp=0 next cycle. Beats already committed by a write remain written.
- Reset mid-transaction -> immediate IDLE; partial write beats remain in the store.
- Read of a never-written line returns undefined data (X in simulation).

Test Plan:
- Write then read, LATENCY=4: write addr 0x0000_0040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44.
  - mem_resp high in cycles t+4..t+7.
  - Read of 0x0000_0040 returns the same 4 beats in order, with mem_resp high t+4..t+7; proto_err=0.
- Aliasing and offset: write 0x0000_0020, then read 0x0000_0220 (index 1, INDEX_BITS=4) -> identical data; read 0x0000_003F -> same line.
- LATENCY=1: read request at cycle t -> mem_resp high t+1..t+4. DONE holds until mem_read drops; the next request is accepted no earlier than 1 cycle after the drop.
- Protocol error: mem_read and mem_write asserted together -> proto_err=1 and a read burst is returned.
  - Separately, drop mem_write after beat 1 -> proto_err=1, state IDLE, beats 0-1 updated, beats 2-3 retain old values.
- Reset mid-burst: assert reset_n=0 during beat 2 of a read.
  - mem_resp=0 and mem_rdata=0 asynchronously.
  - After release, a read of a previously written line still returns the old data.
- Back-to-back: 8 alternating writes and reads to distinct indices -> each read matches its write; exactly 4 resp cycles per transaction; no resp in IDLE/DONE.

Source files
------------

// File: rtl/burst_mem_responder.sv
// Burst memory responder: answers line reads/writes with four 64-bit beats
// after a fixed access latency, backed by a small on-chip line store.
module burst_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic [63:0] mem_rdata,
    output logic        mem_resp,
    output logic        proto_err
);

    localparam int DEPTH = 1 << INDEX_BITS;
    localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

    state_t                  state;
    logic                    op_wr;
    logic [INDEX_BITS-1:0]   idx;
    logic [CW-1:0]           cnt;
    logic [1:0]              beat;
    logic [3:0][63:0]        line_mem [DEPTH];

    logic                    req;
    logic                    acc_wr;
    logic [INDEX_BITS-1:0]   acc_idx;
    logic                    wr_en;
    logic                    unused_addr;

    assign req         = mem_read | mem_write;
    assign acc_wr      = mem_write & ~mem_read;
    assign acc_idx     = mem_addr[5 +: INDEX_BITS];
    assign wr_en       = (state == BURST) && op_wr && req;
    assign unused_addr = ^{mem_addr[31:5+INDEX_BITS], mem_addr[4:0]};

    // Store is deliberately not reset; each write beat commits on its own edge
    always_ff @(posedge clk) begin
        if (wr_en)
            line_mem[idx][beat] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            op_wr     <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            beat      <= '0;
            mem_resp  <= 1'b0;
            mem_rdata <= '0;
            proto_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        op_wr <= acc_wr;
                        idx   <= acc_idx;
                        beat  <= 2'd0;
                        if (mem_read && mem_write)
                            proto_err <= 1'b1;
                        if (LATENCY == 1) begin
                            state    <= BURST;
                            mem_resp <= 1'b1;
                            if (!acc_wr)
                                mem_rdata <= line_mem[acc_idx][0];
                        end else begin
                            cnt   <= CW'(LATENCY - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt == CW'(1)) begin
                        // Launch beat 0 one edge early so it is visible at t+LATENCY
                        cnt      <= '0;
                        state    <= BURST;
                        mem_resp <= 1'b1;
                        if (!op_wr)
                            mem_rdata <= line_mem[idx][0];
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                BURST: begin
                    if (!req) begin
                        proto_err <= 1'b1;
                        mem_resp  <= 1'b0;
                        state     <= IDLE;
                    end else if (beat == 2'd3) begin
                        mem_resp <= 1'b0;
                        state    <= DONE;
                    end else begin
                        beat <= beat + 2'd1;
                        if (!op_wr)
                            mem_rdata <= line_mem[idx][beat + 2'd1];
                    end
                end
                DONE: begin
                    if (!req)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: LATENCY=4 and LATENCY=1 instances checked
// against a per-line, per-beat reference memory.
module tb_burst_mem_responder;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rd_s;
    logic [1:0]       wr_s;
    logic [1:0][31:0] ad_s;
    logic [1:0][63:0] wd_s;
    wire  [1:0]       resp;
    wire  [1:0]       perr;
    wire  [1:0][63:0] rdat;

    burst_mem_responder #(.LATENCY(4), .INDEX_BITS(4)) u_lat4 (
        .clk(clk), .reset_n(reset_n),
        .mem_read(rd_s[0]), .mem_write(wr_s[0]),
        .mem_addr(ad_s[0]), .mem_wdata(wd_s[0]),
        .mem_rdata(rdat[0]), .mem_resp(resp[0]), .proto_err(perr[0])
    );

    burst_mem_responder #(.LATENCY(1), .INDEX_BITS(4)) u_lat1 (
        .clk(clk), .reset_n(reset_n),
        .mem_read(rd_s[1]), .mem_write(wr_s[1]),
        .mem_addr(ad_s[1]), .mem_wdata(wd_s[1]),
        .mem_rdata(rdat[1]), .mem_resp(resp[1]), .proto_err(perr[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] mdl  [2][16][4];
    bit          mval [2][16][4];
    bit          exp_perr [2];
    logic [63:0] pat [4];
    bit          use_pat = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic int lat(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // ev: 0 = normal, 1 = drop request during beat evb, 2 = reset during beat evb
    task automatic txn(input int i, input bit r, input bit w,
                       input logic [31:0] a, input int ev, input int evb,
                       input int hold);
        int          idx;
        int          L;
        int          b;
        bit          is_rd;
        bit          stop;
        bit          lastv;
        logic [63:0] last;
        idx   = int'((a >> 5) % 16);
        L     = lat(i);
        is_rd = r;
        stop  = 1'b0;
        lastv = 1'b0;
        last  = '0;
        @(negedge clk);
        rd_s[i] = r;
        wr_s[i] = w;
        ad_s[i] = a;
        if (r && w)
            exp_perr[i] = 1'b1;
        for (int c = 1; c <= L + 3 && !stop; c++) begin
            @(negedge clk);
            ad_s[i] = $urandom;
            chk($sformatf("resp%0d_c%0d", i, c), 64'(resp[i]), 64'(c >= L));
            if (c >= L) begin
                b = c - L;
                if (is_rd && mval[i][idx][b])
                    chk($sformatf("rdata%0d_l%0d_b%0d", i, idx, b),
                        rdat[i], mdl[i][idx][b]);
                if (is_rd) begin
                    lastv = mval[i][idx][b];
                    last  = mdl[i][idx][b];
                end
                if (ev != 0 && b == evb) begin
                    if (ev == 1) begin
                        rd_s[i] = 1'b0;
                        wr_s[i] = 1'b0;
                        exp_perr[i] = 1'b1;
                        @(negedge clk);
                        chk("abort_resp", 64'(resp[i]), 64'd0);
                    end else begin
                        reset_n = 1'b0;
                        #1;
                        chk("rst_resp", 64'(resp[i]), 64'd0);
                        chk("rst_rdata", rdat[i], 64'd0);
                        exp_perr[0] = 1'b0;
                        exp_perr[1] = 1'b0;
                        rd_s[i] = 1'b0;
                        wr_s[i] = 1'b0;
                        @(negedge clk);
                        reset_n = 1'b1;
                    end
                    stop = 1'b1;
                end else if (!is_rd) begin
                    wd_s[i] = use_pat ? pat[b] : {$urandom, $urandom};
                    mdl[i][idx][b]  = wd_s[i];
                    mval[i][idx][b] = 1'b1;
                end
            end
        end
        if (!stop) begin
            for (int h = 0; h <= hold; h++) begin
                @(negedge clk);
                chk("done_resp", 64'(resp[i]), 64'd0);
                if (is_rd && lastv)
                    chk("rdata_hold", rdat[i], last);
            end
            rd_s[i] = 1'b0;
            wr_s[i] = 1'b0;
            @(negedge clk);
            chk("idle_resp", 64'(resp[i]), 64'd0);
        end
        chk($sformatf("perr%0d", i), 64'(perr[i]), 64'(exp_perr[i]));
    endtask

    initial begin
        rd_s = '0;
        wr_s = '0;
        ad_s = '0;
        wd_s = '0;
        exp_perr[0] = 1'b0;
        exp_perr[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_resp", 64'(resp[i]), 64'd0);
            chk("reset_rdata", rdat[i], 64'd0);
            chk("reset_perr", 64'(perr[i]), 64'd0);
        end
        reset_n = 1'b1;

        // Known pattern write/read, latency 4
        pat[0] = 64'h1111_1111_1111_1111;
        pat[1] = 64'h2222_2222_2222_2222;
        pat[2] = 64'h3333_3333_3333_3333;
        pat[3] = 64'h4444_4444_4444_4444;
        use_pat = 1'b1;
        txn(0, 1'b0, 1'b1, 32'h0000_0040, 0, 0, 0);
        use_pat = 1'b0;
        txn(0, 1'b1, 1'b0, 32'h0000_0040, 0, 0, 1);
        chk("pat_beat3", mdl[0][2][3], 64'h4444_4444_4444_4444);

        // Aliasing and offset bits
        txn(0, 1'b0, 1'b1, 32'h0000_0020, 0, 0, 0);
        txn(0, 1'b1, 1'b0, 32'h0000_0220, 0, 0, 0);
        txn(0, 1'b1, 1'b0, 32'h0000_003F, 0, 0, 0);

        // Latency 1, DONE held for several cycles
        txn(1, 1'b0, 1'b1, 32'h0000_0060, 0, 0, 0);
        txn(1, 1'b1, 1'b0, 32'h0000_0060, 0, 0, 3);
        txn(1, 1'b1, 1'b0, 32'h0000_0060, 0, 0, 0);

        // Read and write together: read burst with error flag
        txn(0, 1'b1, 1'b1, 32'h0000_0040, 0, 0, 0);
        chk("perr_other", 64'(perr[1]), 64'd0);

        // Reset in beat 2 of a read, then old data still present
        txn(0, 1'b1, 1'b0, 32'h0000_0040, 2, 2, 0);
        txn(0, 1'b1, 1'b0, 32'h0000_0040, 0, 0, 0);

        // Write dropped during beat 2: beats 0-1 new, 2-3 old
        txn(0, 1'b0, 1'b1, 32'h0000_0040, 1, 2, 0);
        txn(0, 1'b1, 1'b0, 32'h0000_0040, 0, 0, 0);
        chk("drop_keep2", mdl[0][2][2], 64'h3333_3333_3333_3333);

        // Back-to-back alternating writes/reads on distinct lines
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++) begin
                txn(i, 1'b0, 1'b1, 32'((8 + k) << 5), 0, 0, 0);
                txn(i, 1'b1, 1'b0, 32'((8 + k) << 5), 0, 0, 0);
            end

        // Random traffic
        for (int n = 0; n < 24; n++) begin
            int  i;
            bit  w;
            i = int'($urandom_range(1, 0));
            w = 1'($urandom_range(1, 0));
            txn(i, !w, w, $urandom, 0, 0, int'($urandom_range(2, 0)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
